// File: rtl/z80_regfile_gen_if.sv
// Point-to-point port bundle between the decoder/sequencer (master) and the
// Z80-style register file (slave).
interface z80_regfile_gen_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8
);
    localparam int SEL_W  = $clog2(NUM_REGS);
    localparam int PSEL_W = $clog2(NUM_REGS / 2);

    // No valid/ready: every strobe (wr_en, pw_en, op, ex_af, exx) is a
    // single-cycle command sampled at the rising edge; reads are always valid.
    logic [SEL_W-1:0]    rd_a_sel;
    logic [SEL_W-1:0]    rd_b_sel;
    logic [DATA_W-1:0]   rd_a_data;
    logic [DATA_W-1:0]   rd_b_data;
    logic                wr_en;
    logic [SEL_W-1:0]    wr_sel;
    logic [DATA_W-1:0]   wr_data;
    logic [PSEL_W-1:0]   pr_sel;
    logic [2*DATA_W-1:0] pr_data;
    logic                pw_en;
    logic [PSEL_W-1:0]   pw_sel;
    logic [2*DATA_W-1:0] pw_data;
    logic [1:0]          op;
    logic [PSEL_W-1:0]   op_sel;
    logic                ex_af;
    logic                exx;
    logic                op_zero;
    logic                af_bank;
    logic                main_bank;

    modport master (
        output rd_a_sel, rd_b_sel, wr_en, wr_sel, wr_data, pr_sel,
               pw_en, pw_sel, pw_data, op, op_sel, ex_af, exx,
        input  rd_a_data, rd_b_data, pr_data, op_zero, af_bank, main_bank
    );

    modport slave (
        input  rd_a_sel, rd_b_sel, wr_en, wr_sel, wr_data, pr_sel,
               pw_en, pw_sel, pw_data, op, op_sel, ex_af, exx,
        output rd_a_data, rd_b_data, pr_data, op_zero, af_bank, main_bank
    );
endinterface

// File: rtl/z80_regfile_gen.sv
// Z80-style register file: two byte read ports, byte and pair write ports,
// pair inc/dec unit and optional AF / main shadow banks.
module z80_regfile_gen #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int ALT_BANK = 1
) (
    input logic              clk,
    input logic              reset,
    z80_regfile_gen_if.slave bus
);
    localparam int SEL_W  = $clog2(NUM_REGS);
    localparam int PSEL_W = $clog2(NUM_REGS / 2);
    localparam int NPAIR  = NUM_REGS / 2;
    localparam int PAIR_W = 2 * DATA_W;

    logic [DATA_W-1:0] mem [2][NUM_REGS];
    logic [DATA_W-1:0] cur [NUM_REGS];
    logic [DATA_W-1:0] nxt [NUM_REGS];
    logic              we  [NUM_REGS];
    logic              bsel[NUM_REGS];
    logic              af_bank_q;
    logic              main_bank_q;
    logic              op_zero_q;
    logic              op_act;
    logic [PAIR_W-1:0] op_cur;
    logic [PAIR_W-1:0] op_res;
    logic              rd_a_ok, rd_b_ok, wr_ok, pr_ok, pw_ok, op_ok;

    // Bank 1 is only ever addressed when a flag is set; with ALT_BANK=0 the
    // flags are constant 0, so bank 1 is never written and collapses away.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            bsel[r] = (r < 2) ? af_bank_q : main_bank_q;
            cur[r]  = bsel[r] ? mem[1][r] : mem[0][r];
        end
    end

    assign rd_a_ok = 32'(bus.rd_a_sel) < NUM_REGS;
    assign rd_b_ok = 32'(bus.rd_b_sel) < NUM_REGS;
    assign wr_ok   = 32'(bus.wr_sel) < NUM_REGS;
    assign pr_ok   = 32'(bus.pr_sel) < NPAIR;
    assign pw_ok   = 32'(bus.pw_sel) < NPAIR;
    assign op_ok   = 32'(bus.op_sel) < NPAIR;

    assign bus.rd_a_data = rd_a_ok ? cur[bus.rd_a_sel] : '0;
    assign bus.rd_b_data = rd_b_ok ? cur[bus.rd_b_sel] : '0;
    assign bus.pr_data   = pr_ok ? {cur[{bus.pr_sel, 1'b0}], cur[{bus.pr_sel, 1'b1}]} : '0;

    assign op_act = ((bus.op == 2'b01) || (bus.op == 2'b10)) && op_ok;
    assign op_cur = op_ok ? {cur[{bus.op_sel, 1'b0}], cur[{bus.op_sel, 1'b1}]} : '0;
    assign op_res = (bus.op == 2'b01) ? op_cur + PAIR_W'(1) : op_cur - PAIR_W'(1);

    // Per-byte arbitration: later assignments win, so pw > op > wr.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            nxt[r] = cur[r];
            we[r]  = 1'b0;
            if (bus.wr_en && wr_ok && (bus.wr_sel == SEL_W'(r))) begin
                nxt[r] = bus.wr_data;
                we[r]  = 1'b1;
            end
            if (op_act && (bus.op_sel == PSEL_W'(r / 2))) begin
                nxt[r] = (r % 2 == 0) ? op_res[PAIR_W-1:DATA_W] : op_res[DATA_W-1:0];
                we[r]  = 1'b1;
            end
            if (bus.pw_en && pw_ok && (bus.pw_sel == PSEL_W'(r / 2))) begin
                nxt[r] = (r % 2 == 0) ? bus.pw_data[PAIR_W-1:DATA_W] : bus.pw_data[DATA_W-1:0];
                we[r]  = 1'b1;
            end
        end
    end

    // Writes use the pre-toggle bank mapping held in bsel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < NUM_REGS; r++)
                    mem[b][r] <= '0;
            af_bank_q   <= 1'b0;
            main_bank_q <= 1'b0;
            op_zero_q   <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                if (we[r]) mem[bsel[r]][r] <= nxt[r];
            af_bank_q   <= (ALT_BANK != 0) && (af_bank_q ^ bus.ex_af);
            main_bank_q <= (ALT_BANK != 0) && (main_bank_q ^ bus.exx);
            if (op_act) op_zero_q <= (op_res == '0);
        end
    end

    assign bus.op_zero   = op_zero_q;
    assign bus.af_bank   = af_bank_q;
    assign bus.main_bank = main_bank_q;
endmodule

// File: tb/tb_z80_regfile_gen.sv
// Directed bench for z80_regfile_gen: one shadowed instance and one with
// ALT_BANK=0, sharing clock and reset.
module tb_z80_regfile_gen;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    z80_regfile_gen_if #(.DATA_W(8), .NUM_REGS(8)) b ();
    z80_regfile_gen_if #(.DATA_W(8), .NUM_REGS(8)) b0 ();

    z80_regfile_gen #(.DATA_W(8), .NUM_REGS(8), .ALT_BANK(1)) dut (
        .clk(clk), .reset(reset), .bus(b)
    );
    z80_regfile_gen #(.DATA_W(8), .NUM_REGS(8), .ALT_BANK(0)) dut0 (
        .clk(clk), .reset(reset), .bus(b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [2:0] sel, input logic [7:0] data);
        b.wr_en = 1'b1; b.wr_sel = sel; b.wr_data = data;
        cyc();
        b.wr_en = 1'b0;
    endtask

    task automatic write_pair(input logic [1:0] sel, input logic [15:0] data);
        b.pw_en = 1'b1; b.pw_sel = sel; b.pw_data = data;
        cyc();
        b.pw_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        {b.rd_a_sel, b.rd_b_sel, b.wr_en, b.wr_sel, b.wr_data, b.pr_sel} = '0;
        {b.pw_en, b.pw_sel, b.pw_data, b.op, b.op_sel, b.ex_af, b.exx} = '0;
        {b0.rd_a_sel, b0.rd_b_sel, b0.wr_en, b0.wr_sel, b0.wr_data, b0.pr_sel} = '0;
        {b0.pw_en, b0.pw_sel, b0.pw_data, b0.op, b0.op_sel, b0.ex_af, b0.exx} = '0;
        #1 reset = 1'b0;
        #2;
        checks++; if (b.rd_a_data !== 8'h00) begin errors++; $display("FAIL reset rd_a got %h exp 00", b.rd_a_data); end
        checks++; if (b.rd_b_data !== 8'h00) begin errors++; $display("FAIL reset rd_b got %h exp 00", b.rd_b_data); end
        checks++; if (b.pr_data !== 16'h0000) begin errors++; $display("FAIL reset pr got %h exp 0000", b.pr_data); end
        checks++; if (b.op_zero !== 1'b0) begin errors++; $display("FAIL reset op_zero got %b exp 0", b.op_zero); end
        checks++; if ({b.af_bank, b.main_bank} !== 2'b00) begin errors++; $display("FAIL reset flags got %b exp 00", {b.af_bank, b.main_bank}); end
        cyc(); cyc();
        reset = 1'b1;
    endtask

    task automatic test_byte_pair();
        write_byte(3'd2, 8'h12);
        write_byte(3'd3, 8'h34);
        b.pr_sel = 2'd1; b.rd_a_sel = 3'd2; b.rd_b_sel = 3'd3;
        #1;
        checks++; if (b.pr_data !== 16'h1234) begin errors++; $display("FAIL byte_pair pr got %h exp 1234", b.pr_data); end
        checks++; if (b.rd_a_data !== 8'h12) begin errors++; $display("FAIL byte_pair rd_a got %h exp 12", b.rd_a_data); end
        checks++; if (b.rd_b_data !== 8'h34) begin errors++; $display("FAIL byte_pair rd_b got %h exp 34", b.rd_b_data); end
        b.wr_en = 1'b1; b.wr_sel = 3'd2; b.wr_data = 8'h99;
        #1;
        checks++; if (b.rd_a_data !== 8'h12) begin errors++; $display("FAIL no_bypass rd_a got %h exp 12", b.rd_a_data); end
        cyc();
        b.wr_en = 1'b0;
        checks++; if (b.pr_data !== 16'h9934) begin errors++; $display("FAIL byte_write pr got %h exp 9934", b.pr_data); end
    endtask

    task automatic test_inc_dec();
        write_pair(2'd1, 16'h0001);
        b.pr_sel = 2'd1;
        b.op = 2'b10; b.op_sel = 2'd1;
        cyc();
        checks++; if (b.pr_data !== 16'h0000) begin errors++; $display("FAIL dec1 pr got %h exp 0000", b.pr_data); end
        checks++; if (b.op_zero !== 1'b1) begin errors++; $display("FAIL dec1 op_zero got %b exp 1", b.op_zero); end
        cyc();
        b.op = 2'b00;
        checks++; if (b.pr_data !== 16'hFFFF) begin errors++; $display("FAIL dec_wrap pr got %h exp ffff", b.pr_data); end
        checks++; if (b.op_zero !== 1'b0) begin errors++; $display("FAIL dec_wrap op_zero got %b exp 0", b.op_zero); end
        write_pair(2'd3, 16'hFFFF);
        b.op = 2'b01; b.op_sel = 2'd3; b.pr_sel = 2'd3;
        cyc();
        b.op = 2'b00;
        checks++; if (b.pr_data !== 16'h0000) begin errors++; $display("FAIL inc_wrap pr got %h exp 0000", b.pr_data); end
        checks++; if (b.op_zero !== 1'b1) begin errors++; $display("FAIL inc_wrap op_zero got %b exp 1", b.op_zero); end
        b.op = 2'b11;
        cyc();
        b.op = 2'b00;
        checks++; if (b.op_zero !== 1'b1) begin errors++; $display("FAIL op_zero_hold got %b exp 1", b.op_zero); end
        checks++; if (b.pr_data !== 16'h0000) begin errors++; $display("FAIL op11_noop pr got %h exp 0000", b.pr_data); end
    endtask

    task automatic test_back_to_back();
        b.pr_sel = 2'd1;
        b.op = 2'b01; b.op_sel = 2'd1;
        cyc();
        checks++; if (b.pr_data !== 16'h0000) begin errors++; $display("FAIL b2b_0 pr got %h exp 0000", b.pr_data); end
        cyc();
        checks++; if (b.pr_data !== 16'h0001) begin errors++; $display("FAIL b2b_1 pr got %h exp 0001", b.pr_data); end
        cyc();
        b.op = 2'b00;
        checks++; if (b.pr_data !== 16'h0002) begin errors++; $display("FAIL b2b_2 pr got %h exp 0002", b.pr_data); end
        checks++; if (b.op_zero !== 1'b0) begin errors++; $display("FAIL b2b op_zero got %b exp 0", b.op_zero); end
    endtask

    task automatic test_swap();
        write_byte(3'd0, 8'h55);
        write_byte(3'd2, 8'h66);
        b.ex_af = 1'b1; b.exx = 1'b1;
        cyc();
        b.ex_af = 1'b0; b.exx = 1'b0;
        b.rd_a_sel = 3'd0; b.rd_b_sel = 3'd2;
        #1;
        checks++; if ({b.af_bank, b.main_bank} !== 2'b11) begin errors++; $display("FAIL swap_both flags got %b exp 11", {b.af_bank, b.main_bank}); end
        checks++; if (b.rd_a_data !== 8'h00) begin errors++; $display("FAIL swap_both A got %h exp 00", b.rd_a_data); end
        checks++; if (b.rd_b_data !== 8'h00) begin errors++; $display("FAIL swap_both B got %h exp 00", b.rd_b_data); end
        write_byte(3'd0, 8'hAA);
        b.ex_af = 1'b1;
        cyc();
        b.ex_af = 1'b0;
        checks++; if (b.rd_a_data !== 8'h55) begin errors++; $display("FAIL ex_af A got %h exp 55", b.rd_a_data); end
        checks++; if (b.rd_b_data !== 8'h00) begin errors++; $display("FAIL ex_af B got %h exp 00", b.rd_b_data); end
        b.exx = 1'b1;
        cyc();
        b.exx = 1'b0;
        checks++; if (b.rd_b_data !== 8'h66) begin errors++; $display("FAIL exx B got %h exp 66", b.rd_b_data); end
        b.ex_af = 1'b1;
        cyc();
        b.ex_af = 1'b0;
        checks++; if (b.rd_a_data !== 8'hAA) begin errors++; $display("FAIL shadow A got %h exp aa", b.rd_a_data); end
        b.ex_af = 1'b1;
        cyc();
        b.ex_af = 1'b0;
    endtask

    task automatic test_collision();
        write_pair(2'd2, 16'hFFFF);
        b.pw_en = 1'b1; b.pw_sel = 2'd2; b.pw_data = 16'hBEEF;
        b.op = 2'b01; b.op_sel = 2'd2;
        b.wr_en = 1'b1; b.wr_sel = 3'd4; b.wr_data = 8'h11;
        cyc();
        b.pw_en = 1'b0; b.op = 2'b00; b.wr_en = 1'b0;
        b.pr_sel = 2'd2;
        #1;
        checks++; if (b.pr_data !== 16'hBEEF) begin errors++; $display("FAIL coll_pw pr got %h exp beef", b.pr_data); end
        checks++; if (b.op_zero !== 1'b1) begin errors++; $display("FAIL coll_pw op_zero got %b exp 1", b.op_zero); end
        b.op = 2'b10; b.op_sel = 2'd2;
        b.wr_en = 1'b1; b.wr_sel = 3'd5; b.wr_data = 8'h22;
        cyc();
        b.op = 2'b00; b.wr_en = 1'b0;
        checks++; if (b.pr_data !== 16'hBEEE) begin errors++; $display("FAIL coll_op pr got %h exp beee", b.pr_data); end
        checks++; if (b.op_zero !== 1'b0) begin errors++; $display("FAIL coll_op op_zero got %b exp 0", b.op_zero); end
        b.pw_en = 1'b1; b.pw_sel = 2'd3; b.pw_data = 16'h1357;
        b.op = 2'b01; b.op_sel = 2'd2;
        b.wr_en = 1'b1; b.wr_sel = 3'd0; b.wr_data = 8'h42;
        cyc();
        b.pw_en = 1'b0; b.op = 2'b00; b.wr_en = 1'b0;
        checks++; if (b.pr_data !== 16'hBEEF) begin errors++; $display("FAIL disjoint op pr got %h exp beef", b.pr_data); end
        b.pr_sel = 2'd3; b.rd_a_sel = 3'd0;
        #1;
        checks++; if (b.pr_data !== 16'h1357) begin errors++; $display("FAIL disjoint pw pr got %h exp 1357", b.pr_data); end
        checks++; if (b.rd_a_data !== 8'h42) begin errors++; $display("FAIL disjoint wr A got %h exp 42", b.rd_a_data); end
    endtask

    task automatic test_swap_write();
        b.wr_en = 1'b1; b.wr_sel = 3'd6; b.wr_data = 8'h77; b.exx = 1'b1;
        cyc();
        b.wr_en = 1'b0; b.exx = 1'b0;
        b.rd_a_sel = 3'd6;
        #1;
        checks++; if (b.rd_a_data !== 8'h00) begin errors++; $display("FAIL swap_write shadow got %h exp 00", b.rd_a_data); end
        checks++; if (b.main_bank !== 1'b1) begin errors++; $display("FAIL swap_write main_bank got %b exp 1", b.main_bank); end
        b.exx = 1'b1;
        cyc();
        b.exx = 1'b0;
        checks++; if (b.rd_a_data !== 8'h77) begin errors++; $display("FAIL swap_write main got %h exp 77", b.rd_a_data); end
        checks++; if (b.pr_data !== 16'h7757) begin errors++; $display("FAIL swap_write pr got %h exp 7757", b.pr_data); end
    endtask

    task automatic test_reset_async();
        b.exx = 1'b1;
        cyc();
        b.exx = 1'b0;
        write_pair(2'd2, 16'hFFFF);
        b.op = 2'b01; b.op_sel = 2'd2;
        cyc();
        b.op = 2'b00;
        write_pair(2'd1, 16'h1234);
        b.pr_sel = 2'd1; b.rd_a_sel = 3'd2; b.rd_b_sel = 3'd3;
        #1;
        checks++; if (b.pr_data !== 16'h1234) begin errors++; $display("FAIL pre_reset pr got %h exp 1234", b.pr_data); end
        checks++; if ({b.main_bank, b.op_zero} !== 2'b11) begin errors++; $display("FAIL pre_reset main/opz got %b exp 11", {b.main_bank, b.op_zero}); end
        b.op = 2'b01; b.op_sel = 2'd1; b.ex_af = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++; if (b.pr_data !== 16'h0000) begin errors++; $display("FAIL async_reset pr got %h exp 0000", b.pr_data); end
        checks++; if ({b.rd_a_data, b.rd_b_data} !== 16'h0000) begin errors++; $display("FAIL async_reset rd got %h exp 0000", {b.rd_a_data, b.rd_b_data}); end
        checks++; if ({b.af_bank, b.main_bank, b.op_zero} !== 3'b000) begin errors++; $display("FAIL async_reset flags got %b exp 000", {b.af_bank, b.main_bank, b.op_zero}); end
        b.op = 2'b00; b.ex_af = 1'b0;
        cyc();
        reset = 1'b1;
        b.wr_en = 1'b1; b.wr_sel = 3'd2; b.wr_data = 8'hC3;
        cyc();
        b.wr_en = 1'b0;
        checks++; if (b.rd_a_data !== 8'hC3) begin errors++; $display("FAIL post_reset write got %h exp c3", b.rd_a_data); end
        checks++; if (b.pr_data !== 16'hC300) begin errors++; $display("FAIL post_reset pr got %h exp c300", b.pr_data); end
    endtask

    task automatic test_alt0();
        b0.wr_en = 1'b1; b0.wr_sel = 3'd0; b0.wr_data = 8'h55;
        cyc();
        b0.wr_sel = 3'd2; b0.wr_data = 8'h66;
        cyc();
        b0.wr_sel = 3'd4; b0.wr_data = 8'h77; b0.ex_af = 1'b1; b0.exx = 1'b1;
        cyc();
        b0.wr_en = 1'b0; b0.ex_af = 1'b0; b0.exx = 1'b0;
        b0.rd_a_sel = 3'd0; b0.rd_b_sel = 3'd2; b0.pr_sel = 2'd2;
        #1;
        checks++; if ({b0.af_bank, b0.main_bank} !== 2'b00) begin errors++; $display("FAIL alt0 flags got %b exp 00", {b0.af_bank, b0.main_bank}); end
        checks++; if (b0.rd_a_data !== 8'h55) begin errors++; $display("FAIL alt0 A got %h exp 55", b0.rd_a_data); end
        checks++; if (b0.rd_b_data !== 8'h66) begin errors++; $display("FAIL alt0 B got %h exp 66", b0.rd_b_data); end
        checks++; if (b0.pr_data !== 16'h7700) begin errors++; $display("FAIL alt0 pr got %h exp 7700", b0.pr_data); end
        b0.ex_af = 1'b1;
        cyc();
        b0.ex_af = 1'b0;
        checks++; if (b0.rd_a_data !== 8'h55) begin errors++; $display("FAIL alt0 ex_af A got %h exp 55", b0.rd_a_data); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_byte_pair();
        test_inc_dec();
        test_back_to_back();
        test_swap();
        test_collision();
        test_swap_write();
        test_reset_async();
        test_alt0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
